dmem_arbiter: RTL and testbench

//  Shares the single-port 256x32 data memory between two requesters: port 0 (CPU load/store unit)
//  and port 1 (debug/DMA loader). One memory command issued per cycle; read data returned to the

---
 rtl/dmem_arbiter.sv | 73 +++++++
 tb/tb_dmem_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port 256x32 data memory between two requesters
//   clk, rst_n            : clock, synchronous active-low reset
//   pX_valid_i/ready_o    : request handshake for port X (0 = CPU LSU, 1 = debug/DMA)
//   pX_read_i/writeb_i    : read strobe and byte write enables
//   pX_addr_i/wdata_i     : word address and write data
//   pX_rvalid_o/rdata_o   : read data returned the cycle after the read is granted
//   mem_*_o / mem_rdata_i : combinational command to dmem and its registered read data
module dmem_arbiter #(
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid_i,
  output logic        p0_ready_o,
  input  logic        p0_read_i,
  input  logic [3:0]  p0_writeb_i,
  input  logic [7:0]  p0_addr_i,
  input  logic [31:0] p0_wdata_i,
  output logic        p0_rvalid_o,
  output logic [31:0] p0_rdata_o,
  input  logic        p1_valid_i,
  output logic        p1_ready_o,
  input  logic        p1_read_i,
  input  logic [3:0]  p1_writeb_i,
  input  logic [7:0]  p1_addr_i,
  input  logic [31:0] p1_wdata_i,
  output logic        p1_rvalid_o,
  output logic [31:0] p1_rdata_o,
  output logic        mem_read_o,
  output logic [3:0]  mem_writeb_o,
  output logic [7:0]  mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);
  logic [3:0] wait_q, wait_d;
  logic       last_q, last_d, pend_q, pend_d, id_q, id_d;
  logic       pick1, g0, g1;
  always_comb begin
    // on contention: round-robin picks the port not granted last; fixed mode lets port 1 in once aged out
    pick1 = RR_MODE != 0 ? !last_q : wait_q >= 4'(MAX_WAIT);
    g0 = rst_n & p0_valid_i & !(p1_valid_i & pick1);
    g1 = rst_n & p1_valid_i & (!p0_valid_i | pick1);
    wait_d = (!p1_valid_i | g1) ? 4'd0 : wait_q >= 4'(MAX_WAIT) ? wait_q : wait_q + 4'd1;
    last_d = g1 ? 1'b1 : g0 ? 1'b0 : last_q;
    pend_d = (g0 & p0_read_i) | (g1 & p1_read_i);
    id_d = g1;
    mem_read_o = g0 ? p0_read_i : g1 & p1_read_i;
    mem_writeb_o = g0 ? p0_writeb_i : g1 ? p1_writeb_i : 4'd0;
    mem_addr_o = g0 ? p0_addr_i : g1 ? p1_addr_i : 8'd0;
    mem_wdata_o = g0 ? p0_wdata_i : g1 ? p1_wdata_i : 32'd0;
    // gating with rst_n drops a read response that was in flight when reset arrived
    p0_rvalid_o = rst_n & pend_q & !id_q;
    p1_rvalid_o = rst_n & pend_q & id_q;
    p0_rdata_o = p0_rvalid_o ? mem_rdata_i : 32'd0;
    p1_rdata_o = p1_rvalid_o ? mem_rdata_i : 32'd0;
  end
  assign p0_ready_o = g0;
  assign p1_ready_o = g1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_q <= 4'd0;
      last_q <= 1'b1;
      pend_q <= 1'b0;
      id_q   <= 1'b0;
    end else begin
      wait_q <= wait_d;
      last_q <= last_d;
      pend_q <= pend_d;
      id_q   <= id_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven bench for a fixed-priority and a round-robin dmem_arbiter
module tb_dmem_arbiter;
  typedef struct packed {
    logic v0; logic r0; logic [3:0] w0; logic [7:0] a0; logic [31:0] d0;
    logic v1; logic r1; logic [3:0] w1; logic [7:0] a1; logic [31:0] d1;
    logic [1:0] ga; logic [1:0] gb;
  } vec_t;
  typedef struct packed { logic vld; logic id; logic [31:0] d; } rsp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic p0_valid, p0_read, p1_valid, p1_read;
  logic [3:0] p0_writeb, p1_writeb;
  logic [7:0] p0_addr, p1_addr;
  logic [31:0] p0_wdata, p1_wdata;
  logic a_p0_ready, a_p0_rvalid, a_p1_ready, a_p1_rvalid, a_mem_read;
  logic b_p0_ready, b_p0_rvalid, b_p1_ready, b_p1_rvalid, b_mem_read;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_mem_wdata, a_mem_rdata;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0] a_mem_writeb, b_mem_writeb;
  logic [7:0] a_mem_addr, b_mem_addr;
  logic [31:0] mema [256];
  logic [31:0] memb [256];
  logic [31:0] ref_mem [256];
  rsp_t qa[$], qb[$];
  vec_t tbl[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RR_MODE(0), .MAX_WAIT(4)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .p0_valid_i(p0_valid), .p0_ready_o(a_p0_ready), .p0_read_i(p0_read), .p0_writeb_i(p0_writeb),
    .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_rvalid_o(a_p0_rvalid), .p0_rdata_o(a_p0_rdata),
    .p1_valid_i(p1_valid), .p1_ready_o(a_p1_ready), .p1_read_i(p1_read), .p1_writeb_i(p1_writeb),
    .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_rvalid_o(a_p1_rvalid), .p1_rdata_o(a_p1_rdata),
    .mem_read_o(a_mem_read), .mem_writeb_o(a_mem_writeb), .mem_addr_o(a_mem_addr),
    .mem_wdata_o(a_mem_wdata), .mem_rdata_i(a_mem_rdata));

  dmem_arbiter #(.RR_MODE(1), .MAX_WAIT(4)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_valid_i(p0_valid), .p0_ready_o(b_p0_ready), .p0_read_i(p0_read), .p0_writeb_i(p0_writeb),
    .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata), .p0_rvalid_o(b_p0_rvalid), .p0_rdata_o(b_p0_rdata),
    .p1_valid_i(p1_valid), .p1_ready_o(b_p1_ready), .p1_read_i(p1_read), .p1_writeb_i(p1_writeb),
    .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata), .p1_rvalid_o(b_p1_rvalid), .p1_rdata_o(b_p1_rdata),
    .mem_read_o(b_mem_read), .mem_writeb_o(b_mem_writeb), .mem_addr_o(b_mem_addr),
    .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata));

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return i == 8'h10 ? 32'hDEADBEEF : i == 8'h20 ? 32'hAAAAAAAA : {i, ~i, i, 8'h5A};
  endfunction

  // dmem models: registered read of the pre-write word, byte-enabled writes, preload while in reset
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 256; i++) mema[i] <= init_word(8'(i));
    else for (int k = 0; k < 4; k++) if (a_mem_writeb[k]) mema[a_mem_addr][8*k+:8] <= a_mem_wdata[8*k+:8];
    a_mem_rdata <= mema[a_mem_addr];
  end
  always @(posedge clk) begin
    if (!rst_n) for (int i = 0; i < 256; i++) memb[i] <= init_word(8'(i));
    else for (int k = 0; k < 4; k++) if (b_mem_writeb[k]) memb[b_mem_addr][8*k+:8] <= b_mem_wdata[8*k+:8];
    b_mem_rdata <= memb[b_mem_addr];
  end

  function automatic vec_t mk(input logic v0, r0, input logic [3:0] w0, input logic [7:0] a0,
                              input logic [31:0] d0, input logic v1, r1, input logic [3:0] w1,
                              input logic [7:0] a1, input logic [31:0] d1, input logic [1:0] ga, gb);
    return '{v0, r0, w0, a0, d0, v1, r1, w1, a1, d1, ga, gb};
  endfunction
  function automatic vec_t idle();
    return mk(0, 0, 4'h0, 8'h00, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0, 2'b00, 2'b00);
  endfunction
  function automatic vec_t both(input logic [1:0] ga, gb);
    return mk(1, 1, 4'h0, 8'h01, 32'h0, 1, 1, 4'h0, 8'h02, 32'h0, ga, gb);
  endfunction
  function automatic logic [65:0] exp_rsp(input rsp_t e);
    logic h0, h1;
    h0 = e.vld & !e.id;
    h1 = e.vld & e.id;
    return {h0, h0 ? e.d : 32'h0, h1, h1 ? e.d : 32'h0};
  endfunction
  function automatic logic [44:0] exp_mem(input vec_t v, input logic [1:0] g);
    return g[0] ? {v.r0, v.w0, v.a0, v.d0} : g[1] ? {v.r1, v.w1, v.a1, v.d1} : 45'h0;
  endfunction

  task automatic chk(input string nm, input logic [65:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic ref_write(input logic [3:0] wb, input logic [7:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) if (wb[k]) ref_mem[a][8*k+:8] = d[8*k+:8];
  endtask

  task automatic apply(input vec_t v, input string nm);
    rsp_t ea, eb;
    logic [31:0] rd0, rd1;
    {p0_valid, p0_read, p0_writeb, p0_addr, p0_wdata} = {v.v0, v.r0, v.w0, v.a0, v.d0};
    {p1_valid, p1_read, p1_writeb, p1_addr, p1_wdata} = {v.v1, v.r1, v.w1, v.a1, v.d1};
    @(negedge clk);
    ea = qa.size() > 0 ? qa.pop_front() : '0;
    eb = qb.size() > 0 ? qb.pop_front() : '0;
    chk({nm, " fix rsp"}, {a_p0_rvalid, a_p0_rdata, a_p1_rvalid, a_p1_rdata}, exp_rsp(ea));
    chk({nm, " rr rsp"}, {b_p0_rvalid, b_p0_rdata, b_p1_rvalid, b_p1_rdata}, exp_rsp(eb));
    chk({nm, " fix ready"}, 66'({a_p1_ready, a_p0_ready}), 66'(v.ga));
    chk({nm, " rr ready"}, 66'({b_p1_ready, b_p0_ready}), 66'(v.gb));
    chk({nm, " fix mem"}, 66'({a_mem_read, a_mem_writeb, a_mem_addr, a_mem_wdata}), 66'(exp_mem(v, v.ga)));
    chk({nm, " rr mem"}, 66'({b_mem_read, b_mem_writeb, b_mem_addr, b_mem_wdata}), 66'(exp_mem(v, v.gb)));
    rd0 = ref_mem[v.a0];
    rd1 = ref_mem[v.a1];
    qa.push_back('{vld: (v.ga[0] & v.r0) | (v.ga[1] & v.r1), id: v.ga[1], d: v.ga[1] ? rd1 : rd0});
    qb.push_back('{vld: (v.gb[0] & v.r0) | (v.gb[1] & v.r1), id: v.gb[1], d: v.gb[1] ? rd1 : rd0});
    if (v.ga[0]) ref_write(v.w0, v.a0, v.d0);
    if (v.ga[1]) ref_write(v.w1, v.a1, v.d1);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle(input string nm);
    rst_n = 1'b0;
    {p0_valid, p0_read, p0_writeb, p0_addr, p0_wdata} = {1'b1, 1'b1, 4'hF, 8'h10, 32'h11111111};
    {p1_valid, p1_read, p1_writeb, p1_addr, p1_wdata} = {1'b1, 1'b1, 4'hF, 8'h20, 32'h22222222};
    @(negedge clk);
    chk({nm, " fix ctl"}, 66'({a_p0_ready, a_p1_ready, a_p0_rvalid, a_p1_rvalid, a_mem_read,
        a_mem_writeb, a_mem_addr, a_mem_wdata}), 66'h0);
    chk({nm, " rr ctl"}, 66'({b_p0_ready, b_p1_ready, b_p0_rvalid, b_p1_rvalid, b_mem_read,
        b_mem_writeb, b_mem_addr, b_mem_wdata}), 66'h0);
    chk({nm, " rdata"}, 66'({a_p0_rdata | b_p0_rdata, a_p1_rdata | b_p1_rdata}), 66'h0);
    qa.delete();
    qb.delete();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl.push_back(mk(1, 1, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0, 2'b01, 2'b01));
    tbl.push_back(idle());
    tbl.push_back(mk(0, 0, 4'h0, 8'h00, 32'h0, 1, 0, 4'b0011, 8'h20, 32'h12345678, 2'b10, 2'b10));
    tbl.push_back(mk(0, 0, 4'h0, 8'h00, 32'h0, 1, 1, 4'h0, 8'h20, 32'h0, 2'b10, 2'b10));
    tbl.push_back(idle());
    tbl.push_back(mk(1, 0, 4'h0, 8'h33, 32'h55, 0, 0, 4'h0, 8'h00, 32'h0, 2'b01, 2'b01));
    tbl.push_back(mk(0, 0, 4'h0, 8'h00, 32'h0, 1, 0, 4'h0, 8'h44, 32'h0, 2'b10, 2'b10));
    for (int i = 0; i < 10; i++)
      tbl.push_back(both(i % 5 == 4 ? 2'b10 : 2'b01, i % 2 ? 2'b10 : 2'b01));
    tbl.push_back(idle());
    tbl.push_back(both(2'b01, 2'b01));
    tbl.push_back(both(2'b01, 2'b10));
    tbl.push_back(both(2'b01, 2'b01));
    tbl.push_back(mk(1, 1, 4'h0, 8'h01, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0, 2'b01, 2'b01));
    tbl.push_back(both(2'b01, 2'b10));
    tbl.push_back(both(2'b01, 2'b01));
    tbl.push_back(both(2'b01, 2'b10));
    tbl.push_back(both(2'b01, 2'b01));
    tbl.push_back(both(2'b10, 2'b10));
    tbl.push_back(idle());
    tbl.push_back(mk(1, 1, 4'hF, 8'h40, 32'h0BADF00D, 0, 0, 4'h0, 8'h00, 32'h0, 2'b01, 2'b01));
    tbl.push_back(mk(1, 1, 4'h0, 8'h40, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0, 2'b01, 2'b01));
    tbl.push_back(idle());
    rst_cycle("reset0");
    rst_cycle("reset1");
    rst_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("row%0d", i));
    apply(mk(1, 1, 4'h0, 8'h10, 32'h0, 0, 0, 4'h0, 8'h00, 32'h0, 2'b01, 2'b01), "pre_reset_read");
    rst_cycle("mid_reset");
    rst_n = 1'b1;
    apply(idle(), "post_reset_idle");
    apply(both(2'b01, 2'b01), "post_reset_contend");
    apply(idle(), "post_reset_flush");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
